// File: rtl/result_stream_packer.sv
// result_stream_packer: drains the detection result buffer three words at a
// time (x, y, candidate scale mask) and packs each detection into a single
// 32-bit record on a valid/ready stream. After each frame it emits one
// end-of-frame record that carries the frame id and the number of records sent.
module result_stream_packer #(
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_RESIZE     = 5,
  parameter int COUNT_WIDTH    = 16,
  parameter int FRAME_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     result_data,
  input  logic                      result_empty,
  input  logic                      frame_end,
  output logic                      o_send_result,
  output logic [31:0]               o_out_data,
  output logic                      o_out_valid,
  input  logic                      out_ready,
  output logic [FRAME_ID_WIDTH-1:0] o_frame_id,
  output logic                      o_error
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_X     = 4'd1;
  localparam logic [3:0] S_LT_X     = 4'd2;
  localparam logic [3:0] S_RD_Y     = 4'd3;
  localparam logic [3:0] S_LT_Y     = 4'd4;
  localparam logic [3:0] S_RD_C     = 4'd5;
  localparam logic [3:0] S_LT_C     = 4'd6;
  localparam logic [3:0] S_EMIT     = 4'd7;
  localparam logic [3:0] S_EMIT_EOF = 4'd8;

  // Bit positions inside the packed records.
  localparam int Y_SHIFT    = DATA_WIDTH;
  localparam int C_SHIFT    = 2 * DATA_WIDTH;
  localparam int FID_SHIFT  = COUNT_WIDTH;

  logic [3:0]                state_reg, state_next;
  logic [DATA_WIDTH-1:0]     x_reg, y_reg;
  logic [31:0]               out_data_reg;
  logic [COUNT_WIDTH-1:0]    count_reg;
  logic [FRAME_ID_WIDTH-1:0] frame_id_reg;
  logic                      error_reg;
  logic                      eof_pending_reg;
  logic                      frame_end_d_reg;

  logic                      frame_end_edge;
  logic                      handshake;
  logic [31:0]               det_word;
  logic [31:0]               eof_word;

  // Strobe and valid are decoded straight from the state so that an
  // asynchronous reset removes them in the same instant.
  assign o_send_result = (state_reg == S_RD_X) || (state_reg == S_RD_Y) ||
                         (state_reg == S_RD_C);
  assign o_out_valid   = (state_reg == S_EMIT) || (state_reg == S_EMIT_EOF);
  assign o_out_data    = out_data_reg;
  assign o_frame_id    = frame_id_reg;
  assign o_error       = error_reg;

  assign frame_end_edge = frame_end && !frame_end_d_reg;
  assign handshake      = o_out_valid && out_ready;

  // Record images: the detection word takes the candidate straight off the
  // bus in LT_C (only its low scale bits), the EOF word uses live counters.
  always_comb begin
    det_word = (32'(result_data[NUM_RESIZE-1:0]) << C_SHIFT) |
               (32'(y_reg) << Y_SHIFT) |
               32'(x_reg);
    eof_word = 32'h8000_0000 |
               (32'(frame_id_reg) << FID_SHIFT) |
               32'(count_reg);
  end

  // Next-state logic; waiting data always wins over a pending EOF so a frame
  // is only closed once the buffer has been drained.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (!result_empty)        state_next = S_RD_X;
        else if (eof_pending_reg) state_next = S_EMIT_EOF;
      end
      S_RD_X:     state_next = S_LT_X;
      S_LT_X:     state_next = result_empty ? S_IDLE : S_RD_Y;
      S_RD_Y:     state_next = S_LT_Y;
      S_LT_Y:     state_next = result_empty ? S_IDLE : S_RD_C;
      S_RD_C:     state_next = S_LT_C;
      S_LT_C:     state_next = S_EMIT;
      S_EMIT:     if (out_ready) state_next = S_IDLE;
      S_EMIT_EOF: if (out_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Capture x and y from the bus and freeze the outgoing record image the
  // cycle before it is presented; it is held untouched while waiting on ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      out_data_reg <= '0;
    end else begin
      if (state_reg == S_LT_X) x_reg <= result_data;
      if (state_reg == S_LT_Y) y_reg <= result_data;
      if (state_reg == S_LT_C) out_data_reg <= det_word;
      if (state_reg == S_IDLE && state_next == S_EMIT_EOF) out_data_reg <= eof_word;
    end
  end

  // Per-frame record counter (saturating) and frame id, both advanced only
  // on accepted records.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= '0;
      frame_id_reg <= '0;
    end else if (handshake) begin
      if (state_reg == S_EMIT_EOF) begin
        count_reg    <= '0;
        frame_id_reg <= frame_id_reg + 1'b1;
      end else if (count_reg != '1) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Frame end edge detect; a new edge outranks the EOF handshake clearing the
  // flag, so an edge landing on that cycle opens the next EOF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_end_d_reg <= 1'b0;
      eof_pending_reg <= 1'b0;
    end else begin
      frame_end_d_reg <= frame_end;
      if (frame_end_edge)
        eof_pending_reg <= 1'b1;
      else if (handshake && state_reg == S_EMIT_EOF)
        eof_pending_reg <= 1'b0;
    end
  end

  // Sticky error: the buffer ran dry before a detection was fully read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error_reg <= 1'b0;
    else if ((state_reg == S_LT_X || state_reg == S_LT_Y) && result_empty)
      error_reg <= 1'b1;
  end

endmodule

// File: tb/tb_result_stream_packer.sv
// Bench for result_stream_packer: a queue models the result buffer, a record
// queue holds what the host should receive, and hand-built cases cover
// timing, backpressure, errors, frame id wrap and asynchronous reset.
module tb_result_stream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] result_data;
  logic        result_empty;
  logic        frame_end;
  logic        out_ready;
  logic        o_send_result;
  logic [31:0] o_out_data;
  logic        o_out_valid;
  logic [7:0]  o_frame_id;
  logic        o_error;

  always #5 clk = ~clk;

  result_stream_packer dut (
    .clk          (clk),
    .reset        (reset),
    .result_data  (result_data),
    .result_empty (result_empty),
    .frame_end    (frame_end),
    .o_send_result(o_send_result),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .out_ready    (out_ready),
    .o_frame_id   (o_frame_id),
    .o_error      (o_error)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[6];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          valid_cycles = 0;
  bit          rand_ready = 1'b0;
  logic [11:0] buf_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc[$];
  int          strobe_q[$];
  logic [31:0] exp_q[$];
  int          exp_count = 0;
  int          exp_fid = 0;

  function automatic logic [31:0] ref_det(input int x, input int y, input int c);
    return 32'((c % 32) * 16777216 + y * 4096 + x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: observe strobe/handshake before the edge, serve the buffer
  // just after it, and check that a held record stays put.
  task automatic step();
    bit hs, st, hold;
    logic [31:0] d;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    hs   = (o_out_valid === 1'b1) && (out_ready === 1'b1);
    st   = (o_send_result === 1'b1);
    hold = (o_out_valid === 1'b1) && (out_ready !== 1'b1);
    d    = o_out_data;
    if (o_out_valid === 1'b1) valid_cycles++;
    @(posedge clk);
    #1;
    if (hs) begin
      acc_q.push_back(d);
      acc_cyc.push_back(cyc);
    end
    if (st) begin
      strobe_q.push_back(cyc);
      if (buf_q.size() > 0) result_data = buf_q.pop_front();
    end
    result_empty = (buf_q.size() == 0);
    if (hold) begin
      check("hold_valid", 32'(o_out_valid), 32'd1);
      check("hold_data", o_out_data, d);
    end
    cyc++;
  endtask

  task automatic push_det(input logic [11:0] x, input logic [11:0] y,
                          input logic [11:0] c, input bit model);
    buf_q.push_back(x);
    buf_q.push_back(y);
    buf_q.push_back(c);
    result_empty = 1'b0;
    if (model) begin
      exp_q.push_back(ref_det(int'(x), int'(y), int'(c)));
      if (exp_count < 65535) exp_count++;
    end
  endtask

  task automatic expect_eof();
    exp_q.push_back(32'h8000_0000 + 32'(exp_fid) * 32'd65536 + 32'(exp_count));
    exp_fid   = (exp_fid + 1) % 256;
    exp_count = 0;
  endtask

  task automatic wait_acc(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (acc_q.size() < n && k < bound) begin
      step();
      k++;
    end
    check({name, "_arrive"}, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    while (acc_q.size() > 0 && exp_q.size() > 0)
      check({name, "_record"}, acc_q.pop_front(), exp_q.pop_front());
    acc_q.delete();
    exp_q.delete();
    acc_cyc.delete();
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    bit dbl;

    vt[0] = '{12'h123, 12'h045, 12'h011, 32'h1104_5123};
    vt[1] = '{12'hFFF, 12'hFFF, 12'hFFF, 32'h1FFF_FFFF};
    vt[2] = '{12'h000, 12'h000, 12'h000, 32'h0000_0000};
    vt[3] = '{12'hABC, 12'h123, 12'hFE0, 32'h0012_3ABC};
    vt[4] = '{12'h001, 12'h800, 12'h03F, 32'h1F80_0001};
    vt[5] = '{12'h7FF, 12'h001, 12'h00A, 32'h0A00_17FF};

    reset = 1'b1; frame_end = 1'b0; out_ready = 1'b0;
    result_empty = 1'b1; result_data = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_send", 32'(o_send_result), 32'd0);
    check("rst_valid", 32'(o_out_valid), 32'd0);
    check("rst_data", o_out_data, 32'd0);
    check("rst_fid", 32'(o_frame_id), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) step();

    // Backpressure during the first EMIT with a second detection queued.
    out_ready = 1'b0;
    push_det(12'h321, 12'h654, 12'h007, 1'b1);
    push_det(12'h0AA, 12'h0BB, 12'h01C, 1'b1);
    k = 0;
    while (o_out_valid !== 1'b1 && k < 20) begin step(); k++; end
    check("bp_valid", 32'(o_out_valid), 32'd1);
    n = strobe_q.size();
    repeat (10) step();
    check("bp_no_strobe", 32'(strobe_q.size()), 32'(n));
    check("bp_no_accept", 32'(acc_q.size()), 32'd0);
    out_ready = 1'b1;
    wait_acc(2, 40, "bp");
    compare_stream("bp");

    // EOF after two accepted records.
    pulse_frame_end();
    expect_eof();
    wait_acc(1, 20, "eof0");
    if (acc_q.size() > 0) check("eof0_word", acc_q[0], 32'h8000_0002);
    compare_stream("eof0");
    check("eof0_fid", 32'(o_frame_id), 32'd1);

    // Table vectors: packing and read cadence.
    for (int i = 0; i < 6; i++) begin
      strobe_q.delete();
      valid_cycles = 0;
      push_det(vt[i].x, vt[i].y, vt[i].c, 1'b0);
      exp_count++;
      wait_acc(1, 30, "vec");
      repeat (2) step();
      if (acc_q.size() > 0) check("vec_data", acc_q[0], vt[i].exp);
      check("vec_strobes", 32'(strobe_q.size()), 32'd3);
      if (strobe_q.size() == 3 && acc_cyc.size() > 0) begin
        check("vec_gap1", 32'(strobe_q[1] - strobe_q[0]), 32'd2);
        check("vec_gap2", 32'(strobe_q[2] - strobe_q[1]), 32'd2);
        check("vec_latency", 32'(acc_cyc[0] - strobe_q[0]), 32'd6);
      end
      check("vec_valid_len", 32'(valid_cycles), 32'd1);
      acc_q.delete();
      acc_cyc.delete();
    end

    // frame_end toggles twice while a record is mid-read: record, then one EOF.
    push_det(12'h456, 12'h789, 12'h015, 1'b1);
    repeat (3) step();
    frame_end = 1'b1; step();
    frame_end = 1'b0; step();
    frame_end = 1'b1; step();
    frame_end = 1'b0;
    expect_eof();
    wait_acc(2, 40, "mid");
    repeat (20) step();
    compare_stream("mid");
    check("mid_fid", 32'(o_frame_id), 32'(exp_fid));

    // Buffer runs empty at LT_Y.
    strobe_q.delete();
    buf_q.push_back(12'h111);
    buf_q.push_back(12'h222);
    result_empty = 1'b0;
    repeat (12) step();
    check("err_flag", 32'(o_error), 32'd1);
    check("err_no_record", 32'(acc_q.size()), 32'd0);
    check("err_strobes", 32'(strobe_q.size()), 32'd2);
    check("err_idle", 32'(o_send_result | o_out_valid), 32'd0);
    push_det(12'h0F0, 12'h0E0, 12'h00D, 1'b1);
    wait_acc(1, 30, "err_next");
    compare_stream("err_next");
    check("err_sticky", 32'(o_error), 32'd1);

    // Randomised frames with random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++)
        push_det(12'($urandom), 12'($urandom), 12'($urandom), 1'b1);
      dbl = (n > 0) && ($urandom_range(0, 1) == 1);
      pulse_frame_end();
      if (dbl) pulse_frame_end();
      expect_eof();
      wait_acc(n + 1, 600, "rnd");
      repeat (10) step();
      compare_stream("rnd");
      check("rnd_fid", 32'(o_frame_id), 32'(exp_fid));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // Empty frames until the frame id wraps back to zero.
    while (exp_fid != 0) begin
      if (exp_fid == 255) check("wrap_255", 32'(o_frame_id), 32'd255);
      pulse_frame_end();
      expect_eof();
      wait_acc(1, 20, "wrap");
      compare_stream("wrap");
    end
    check("wrap_zero", 32'(o_frame_id), 32'd0);

    // Asynchronous reset while a record is presented.
    out_ready = 1'b0;
    push_det(12'h5A5, 12'h3C3, 12'h012, 1'b0);
    k = 0;
    while (o_out_valid !== 1'b1 && k < 20) begin step(); k++; end
    check("ar_valid_before", 32'(o_out_valid), 32'd1);
    check("ar_data_before", o_out_data, 32'h123C_35A5);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", 32'(o_out_valid), 32'd0);
    check("ar_data", o_out_data, 32'd0);
    check("ar_send", 32'(o_send_result), 32'd0);
    check("ar_error", 32'(o_error), 32'd0);
    check("ar_fid", 32'(o_frame_id), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    buf_q.delete();
    result_empty = 1'b1;
    acc_q.delete();
    exp_q.delete();
    repeat (3) step();
    check("ar_idle", 32'(o_out_valid | o_send_result), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
